// File: rtl/counter_ctrl_pkg.sv
// Shared state encodings for the counter sequencer and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/counter_sequencer_rise_edge.sv
// 1-bit rising-edge detector on an already-synchronised level input.
// Latency: rise is combinational from level; history register updates every clk.
// Backpressure: none; a level held high yields exactly one rise.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember last cycle's level so a new assertion can be told from a held one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/stop sequencer driving an external counter's enable, load and direction pins.
// Latency: request edge to state_out/strobes is one clk; first cnt_en lands DIV clks after entering RUN.
// Backpressure: none; strobes are single-cycle pulses and requests are edge-triggered.
module counter_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 12500000,
  parameter int PRE_W = 24,
  parameter int WRAP  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               load_req,
  input  logic               dir_sw,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   count_in,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  output logic [STATE_W-1:0] state_out,
  output logic               done
);

  // A one-cycle tick period would let the limit compare see a stale count_in.
  if (DIV < 2) begin : g_div_check
    $error("counter_sequencer: DIV must be at least 2");
  end
  if ((64'd1 << PRE_W) < 64'(DIV)) begin : g_pre_check
    $error("counter_sequencer: PRE_W too narrow to hold DIV-1");
  end

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic start_rise, stop_rise, load_rise;

  rise_edge u_start_edge (.clk(clk), .rst(rst), .level(start),    .rise(start_rise));
  rise_edge u_stop_edge  (.clk(clk), .rst(rst), .level(stop),     .rise(stop_rise));
  rise_edge u_load_edge  (.clk(clk), .rst(rst), .level(load_req), .rise(load_rise));

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               en_d, load_d, up_d, tick, at_limit;
  logic [WIDTH-1:0]   load_val_d;

  // Terminal test uses the frozen direction, so a mid-run switch flip cannot move the limit.
  assign at_limit  = cnt_up ? (count_in == limit) : (count_in == '0);
  assign state_out = state_q;

  // State, prescaler and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      cnt_en       <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_up       <= 1'b1;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_en       <= en_d;
      cnt_load     <= load_d;
      cnt_load_val <= load_val_d;
      cnt_up       <= up_d;
      done         <= (state_d == ST_DONE);
    end
  end

  // Next state and strobes; stop outranks load, which outranks start.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    en_d       = 1'b0;
    load_d     = 1'b0;
    load_val_d = cnt_load_val;
    up_d       = cnt_up;
    tick       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        up_d = dir_sw;
        // A stop edge does nothing here but still masks a coincident load or start.
        if (!stop_rise) begin
          if (load_rise) begin
            load_d     = 1'b1;
            load_val_d = load_val;
          end else if (start_rise) begin
            state_d = ST_RUN;
            pre_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (stop_rise) begin
          state_d = ST_PAUSED;
        end else begin
          tick  = (pre_q == PRE_LAST);
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (!at_limit) begin
              en_d = 1'b1;
            end else if (WRAP != 0) begin
              load_d     = 1'b1;
              load_val_d = cnt_up ? '0 : limit;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_PAUSED: begin
        up_d = dir_sw;
        if (stop_rise) begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end else if (load_rise) begin
          load_d     = 1'b1;
          load_val_d = load_val;
        end else if (start_rise) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop_rise) begin
          state_d = ST_IDLE;
        end else if (load_rise) begin
          load_d     = 1'b1;
          load_val_d = load_val;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run/pause/stop controller that sequences the board's synchronous N-bit counter datapath.
- Generates rate-controlled enable pulses from the fast system clock, replacing a raw divided clock.
- Owns direction and parallel-load control, and watches counter feedback to stop or wrap at a programmable limit.
- Sits between the pushbutton/switch inputs (already debounced and synchronised to clk) and the counter's enable/load/direction pins; the counter is clocked by the same clk.

Parameters:
WIDTH, 4, counter data width in bits
DIV, 12500000, clk cycles per count tick; must be >= 2 (elaboration-time check fails otherwise)
PRE_W, 24, prescaler register width; must satisfy 2^PRE_W >= DIV
WRAP, 0, 1 = reload and keep running at limit; 0 = stop in DONE at limit

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level request; rising edge starts or resumes
stop  input  1  level request; rising edge pauses, or from PAUSED/DONE returns to IDLE
load_req  input  1  level request; rising edge requests a parallel load of load_val
dir_sw  input  1  1 = count up, 0 = count down
load_val  input  WIDTH  value loaded into the counter on a load request
limit  input  WIDTH  terminal count when counting up; reload value when counting down with WRAP=1
count_in  input  WIDTH  current counter value (feedback)
cnt_en  output  1  one-cycle counter enable pulse
cnt_up  output  1  direction to counter, held stable while RUN
cnt_load  output  1  one-cycle parallel-load strobe
cnt_load_val  output  WIDTH  data accompanying cnt_load
state_out  output  2  current state encoding
done  output  1  high while in DONE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cnt_en=0, cnt_load=0, cnt_load_val=0, cnt_up=1, done=0, prescaler=0, edge-detect history=0.
- Edge detect: each request input is registered each cycle; edge = in & ~in_q. An input first seen high at edge k takes effect at edge k (one-cycle latency to state_out).
- States and encodings: IDLE=00, RUN=01, PAUSED=10, DONE=11.
- Priority on simultaneous edges: stop > load_req > start. A stop edge also suppresses any tick in that cycle.
- cnt_up tracks dir_sw every cycle in IDLE and PAUSED. It is frozen in RUN and DONE.
- IDLE:
  - start -> RUN, prescaler cleared to 0.
  - load_req -> cnt_load=1 for one cycle with cnt_load_val=load_val; state stays IDLE.
  - stop ignored.
- RUN:
  - Prescaler counts 0..DIV-1; at DIV-1 it resets to 0 and a tick occurs.
  - On a tick: at_limit = cnt_up ? (count_in==limit) : (count_in==0).
  - Tick with !at_limit -> cnt_en=1 next cycle.
  - Tick with at_limit and WRAP=0 -> DONE, no cnt_en.
  - Tick with at_limit and WRAP=1 -> cnt_load=1 with cnt_load_val = cnt_up ? 0 : limit, no cnt_en; state stays RUN.
  - stop -> PAUSED; prescaler value held.
  - load_req and start ignored.
  - First cnt_en appears exactly DIV cycles after the edge that entered RUN.
- PAUSED:
  - start -> RUN; prescaler resumes from the held value.
  - stop -> IDLE, prescaler cleared.
  - load_req -> cnt_load pulse; state stays PAUSED.
- DONE:
  - done=1.
  - stop -> IDLE.
  - load_req -> cnt_load pulse and -> IDLE.
  - start ignored.
- cnt_en and cnt_load are never high in the same cycle; each is a one-cycle pulse.
- DIV>=2 guarantees count_in reflects the previous cnt_en/cnt_load before the next limit compare.
- Limit compares are WIDTH-bit unsigned equality; no arithmetic beyond the prescaler increment.
- If limit < count_in while counting up with WRAP=0, counting continues through the counter's natural 2^WIDTH wrap until equality.
- rst asserted mid-operation: all registers return to reset values immediately (asynchronous). Pulses in flight are dropped.

Decomposition:
- Shared package counter_ctrl_pkg holds the state encodings (IDLE/RUN/PAUSED/DONE) and the STATE_W=2 constant.
- One sub-module, rise_edge: 1-bit registered rising-edge detector with clk/rst, instantiated three times.
- The prescaler and FSM stay in counter_sequencer.

Test Plan:
All scenarios use WIDTH=4, DIV=4, with a behavioural 4-bit counter model in the bench.
- Reset then start pulse, limit=9, up, WRAP=0: cnt_en pulses every 4 cycles, first 4 cycles after RUN; counter reaches 9; next tick -> state 11, done=1, no further cnt_en.
- Same setup with WRAP=1: at count 9, the next tick gives cnt_load=1 with cnt_load_val=0; counting continues 0,1,2...
- Down count from load_val=3, dir_sw=0, WRAP=1, limit=9: sequence 3,2,1,0, then cnt_load with cnt_load_val=9.
- In RUN at prescaler=2, assert stop, wait 10 cycles, then start: PAUSED with no cnt_en; after resume, next cnt_en comes 2 cycles later. Toggling dir_sw during RUN leaves cnt_up unchanged.
- Same-cycle start and stop edges in IDLE: stays IDLE. Same-cycle stop and tick in RUN: PAUSED with no cnt_en. load_req in RUN: no cnt_load.
- Assert rst mid-RUN while cnt_en=1: all outputs go to reset values in that cycle; state_out=00.
